pulse_emitter: RTL and testbench
================================

// Module: pulse_emitter
// PURPOSE
//  Transmit side of the single-cycle pulse signalling used by the pulse detector.
//  - Accepts a burst request: pulse count plus inter-pulse gap.
//  - Drives isolated one-cycle-high pulses on pulse_out.
//  - Every pulse is framed 0->1->0, so a downstream 2-deep history detector counts each pulse exactly once.
//  - Sits between control logic and the pulse line feeding the detector.
// PARAMETERS
//  CNT_W  default 8   width of req_count; max burst = 2^CNT_W-1 pulses
//  GAP_W  default 4   width of req_gap; low cycles between pulses
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  req_valid   in   1      burst request valid
//  req_count   in   CNT_W  number of pulses in burst
//  req_gap     in   GAP_W  low cycles after each pulse; 0 treated as 1
//  req_ready   out  1      emitter can accept a request
//  abort       in   1      cancel burst in progress
//  pulse_out   out  1      registered pulse line
//  busy        out  1      burst in progress
//  done        out  1      one-cycle strobe: burst completed normally
//  sent_total  out  16     emitted-pulse count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; pulse_out=0, busy=0, done=0, req_ready=1, sent_total=0.
//    Reset mid-burst drops the burst immediately; no done strobe.
//  - Handshake:
//    - Accept on a rising edge where req_valid & req_ready.
//    - Latch count C and gap G = (req_gap==0) ? 1 : req_gap.
//    - req_ready = (state==IDLE). busy = ~req_ready.
//    - req_count/req_gap are ignored while busy.
//  - States: IDLE, PULSE, GAP.
//    - IDLE -> PULSE on accept with C>0.
//    - PULSE (1 cycle, pulse_out=1): decrement remaining, then -> GAP.
//    - GAP (G cycles, pulse_out=0): when gap counter expires, -> PULSE if remaining>0, else -> IDLE with done=1 in the first IDLE cycle.
//  - Timing for accept at edge N:
//    - Pulse k (k=0..C-1) is high in cycle N+1+k*(G+1).
//    - done is high in cycle N+1+C*(G+1).
//    - req_ready=1 in that same cycle, so back-to-back acceptance is legal.
//    - The preceding IDLE/GAP low cycle guarantees a leading 0 before the next pulse.
//  - C=0: accepted, no pulse; state stays IDLE; done=1 in cycle N+1.
//  - pulse_out is driven only from a flop; no combinational path from inputs.
//  - abort:
//    - Sampled at any edge while busy: next cycle state=IDLE, pulse_out=0, done=0, remaining cleared.
//    - If abort is sampled in the PULSE cycle, that pulse has already been emitted and still counts.
//    - abort while IDLE is ignored.
//    - abort has priority over a coincident accept, so no accept occurs that edge.
//  - Gap counter width is GAP_W; remaining-count width is CNT_W; neither wraps (decrement only while >0).
// CONFIGURATION
//  PULSE_EMITTER_STATS_EN defined:
//   - sent_total increments on every cycle with pulse_out=1.
//   - Saturates at 16'hFFFF; cleared only by rst_n.
//  Not defined:
//   - sent_total tied to 16'h0000; no counter flops synthesised.
// TESTING
//  1. Reset, then C=3, G=2 accepted at edge N
//     -> pulse_out=1 only in cycles N+1, N+4, N+7; done=1 in N+10 only;
//        busy=1 in N+1..N+9; a detector model reports exactly 3.
//  2. C=2, req_gap=0 -> gap forced to 1: pulses at N+1, N+3; done at N+5;
//     pulse_out never high two consecutive cycles.
//  3. C=0 -> no pulse; done=1 at N+1; req_ready stays 1 throughout.
//  4. C=5, G=3 with abort asserted in cycle of pulse 2 (N+9)
//     -> pulse 2 emitted; pulse_out=0, busy=0, req_ready=1 from N+10; no done;
//        sent_total=3 when STATS_EN is defined.
//  5. Back-to-back: hold req_valid high with C=1, G=1
//     -> second accept at the done cycle; pulses at N+1, N+4; each framed by lows.
//  6. rst_n pulsed low mid-GAP -> all outputs at reset values immediately; sent_total=0;
//     with STATS_EN undefined, sent_total=0 throughout all tests.

Source files
------------

// File: rtl/pulse_emitter_if.sv
// rtl/pulse_emitter_if.sv - burst request / pulse line bundle between control logic and pulse_emitter
interface pulse_emitter_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             req_valid;
    logic [CNT_W-1:0] req_count;
    logic [GAP_W-1:0] req_gap;
    logic             req_ready;
    logic             abort;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [15:0]      sent_total;

    modport master (
        output req_valid, req_count, req_gap, abort,
        input  req_ready, pulse_out, busy, done, sent_total
    );

    modport slave (
        input  req_valid, req_count, req_gap, abort,
        output req_ready, pulse_out, busy, done, sent_total
    );
endinterface

// File: rtl/pulse_emitter.sv
// rtl/pulse_emitter.sv - emits bursts of isolated one-cycle pulses with a programmable low gap
// Optional emitted-pulse counter on sent_total enabled by PULSE_EMITTER_STATS_EN.
module pulse_emitter #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    pulse_emitter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] w_gap_len_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic [GAP_W-1:0] w_gap_req;
    logic             r_pulse;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_busy;
    logic             w_accept;

    assign w_busy    = (r_state != S_IDLE);
    assign w_accept  = bus.req_valid && !w_busy;
    assign w_gap_req = (bus.req_gap == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : bus.req_gap;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_gap_len_nxt   = r_gap_len;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_done_nxt      = 1'b0;
        if (w_busy && bus.abort) begin
            // a pulse already on the line this cycle stays emitted; only the rest is dropped
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
            w_gap_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_gap_len_nxt   = w_gap_req;
                        w_remaining_nxt = bus.req_count;
                        if (bus.req_count != '0) begin
                            w_state_nxt = S_PULSE;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - 1'b1;
                    end
                    w_gap_cnt_nxt = r_gap_len;
                    w_state_nxt   = S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt > {{(GAP_W-1){1'b0}}, 1'b1}) begin
                        w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                    end else begin
                        w_gap_cnt_nxt = '0;
                        if (r_remaining != '0) begin
                            w_state_nxt = S_PULSE;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_gap_len   <= {{(GAP_W-1){1'b0}}, 1'b1};
            r_gap_cnt   <= '0;
            r_pulse     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_gap_len   <= w_gap_len_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            // pulse line mirrors the registered state so it is glitch-free
            r_pulse     <= (w_state_nxt == S_PULSE);
            r_done      <= w_done_nxt;
        end
    end

`ifdef PULSE_EMITTER_STATS_EN
    logic [15:0] r_sent_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sent_total <= 16'h0000;
        end else if (r_pulse && (r_sent_total != 16'hFFFF)) begin
            r_sent_total <= r_sent_total + 16'd1;
        end
    end

    assign bus.sent_total = r_sent_total;
`else
    assign bus.sent_total = 16'h0000;
`endif

    assign bus.req_ready = !w_busy;
    assign bus.busy      = w_busy;
    assign bus.pulse_out = r_pulse;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_pulse_emitter.sv
// tb/tb_pulse_emitter.sv - directed and randomized bench for pulse_emitter against a schedule model
module tb_pulse_emitter;
    localparam int MAXC = 65536;

    logic clk;
    logic rst_n;

    pulse_emitter_if #(.CNT_W(8), .GAP_W(4)) bus ();

    pulse_emitter #(.CNT_W(8), .GAP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // model: per-cycle schedule of expected pulses/done strobes, and the first cycle the emitter is free
    bit exp_pulse [MAXC];
    bit exp_done  [MAXC];
    int cur;
    int m_free;
    int m_sent;

    int obs_pulse[$];
    int obs_done[$];
    int obs_busy_n;
    int obs_notready_n;
    int det_cnt;
    logic prev_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle=%0d got=%0h want=%0h", name, cur, act, exp);
        end
    endtask

    task automatic chk_list(input string name, input int q[$], input int e[$]);
        bit ok;
        ok = (q.size() == e.size());
        for (int i = 0; i < q.size(); i++) begin
            if (ok && q[i] != e[i]) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got cycles %p want %p", name, q, e);
        end
    endtask

    task automatic clr(input int from, input int upto);
        for (int i = from; i <= upto && i < MAXC; i++) begin
            exp_pulse[i] = 1'b0;
            exp_done[i]  = 1'b0;
        end
    endtask

    function automatic int exp_sent();
`ifdef PULSE_EMITTER_STATS_EN
        return m_sent;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        int e;
        int c;
        int g;
        e = cur;
        if (!rst_n) begin
            clr(e + 1, (m_free > e + 1) ? m_free : e + 1);
            m_free = 0;
            m_sent = 0;
        end else begin
            if (exp_pulse[e] && m_sent < 65535) m_sent++;
            if (bus.abort && e < m_free) begin
                clr(e + 1, m_free);
                m_free = e + 1;
            end else if (bus.req_valid && e >= m_free) begin
                c = int'(bus.req_count);
                g = (bus.req_gap == 0) ? 1 : int'(bus.req_gap);
                for (int k = 0; k < c; k++) exp_pulse[e + 1 + k * (g + 1)] = 1'b1;
                m_free = e + 1 + c * (g + 1);
                exp_done[m_free] = 1'b1;
            end
        end
        cur = e + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_pulse", {31'd0, bus.pulse_out}, 0);
            chk("rst_busy",  {31'd0, bus.busy}, 0);
            chk("rst_done",  {31'd0, bus.done}, 0);
            chk("rst_ready", {31'd0, bus.req_ready}, 1);
            chk("rst_sent",  {16'd0, bus.sent_total}, 0);
        end else begin
            chk("pulse", {31'd0, bus.pulse_out}, {31'd0, exp_pulse[cur]});
            chk("done",  {31'd0, bus.done}, {31'd0, exp_done[cur]});
            chk("busy",  {31'd0, bus.busy}, (cur < m_free) ? 1 : 0);
            chk("ready", {31'd0, bus.req_ready}, (cur >= m_free) ? 1 : 0);
            chk("sent",  {16'd0, bus.sent_total}, exp_sent());
            chk("isolated", {31'd0, prev_pulse & bus.pulse_out}, 0);
            if (bus.pulse_out) obs_pulse.push_back(cur);
            if (bus.done) obs_done.push_back(cur);
            if (bus.busy) obs_busy_n++;
            if (!bus.req_ready) obs_notready_n++;
            if (bus.pulse_out && !prev_pulse) det_cnt++;
        end
        prev_pulse = bus.pulse_out;
    end

    task automatic obs_clear();
        obs_pulse.delete();
        obs_done.delete();
        obs_busy_n     = 0;
        obs_notready_n = 0;
        det_cnt        = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("async_pulse", {31'd0, bus.pulse_out}, 0);
        chk("async_busy",  {31'd0, bus.busy}, 0);
        chk("async_done",  {31'd0, bus.done}, 0);
        chk("async_ready", {31'd0, bus.req_ready}, 1);
        chk("async_sent",  {16'd0, bus.sent_total}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
    endtask

    task automatic request(input int c, input int g);
        bus.req_valid = 1'b1;
        bus.req_count = 8'(c);
        bus.req_gap   = 4'(g);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int q[$];
        total = 0;
        bad = 0;
        cur = 0;
        m_free = 0;
        m_sent = 0;
        prev_pulse = 1'b0;
        obs_clear();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_count = '0;
        bus.req_gap   = '0;
        bus.abort     = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);
        chk("init_ready", {31'd0, bus.req_ready}, 1);
        chk("init_sent",  {16'd0, bus.sent_total}, 0);

        // C=3 G=2
        obs_clear();
        n = cur;
        request(3, 2);
        tick(12);
        q = {n + 1, n + 4, n + 7};
        chk_list("t1_pulses", obs_pulse, q);
        q = {n + 10};
        chk_list("t1_done", obs_done, q);
        chk("t1_busy_cycles", obs_busy_n, 9);
        chk("t1_detector", det_cnt, 3);

        // gap 0 forced to 1
        obs_clear();
        n = cur;
        request(2, 0);
        tick(8);
        q = {n + 1, n + 3};
        chk_list("t2_pulses", obs_pulse, q);
        q = {n + 5};
        chk_list("t2_done", obs_done, q);

        // C=0
        obs_clear();
        n = cur;
        request(0, 3);
        tick(4);
        q = {};
        chk_list("t3_pulses", obs_pulse, q);
        q = {n + 1};
        chk_list("t3_done", obs_done, q);
        chk("t3_notready", obs_notready_n, 0);

        // abort in the cycle of pulse 2
        do_reset();
        obs_clear();
        n = cur;
        request(5, 3);
        tick(8);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("t4_ready_after_abort", {31'd0, bus.req_ready}, 1);
        tick(10);
        q = {n + 1, n + 5, n + 9};
        chk_list("t4_pulses", obs_pulse, q);
        q = {};
        chk_list("t4_done", obs_done, q);
`ifdef PULSE_EMITTER_STATS_EN
        chk("t4_sent_total", {16'd0, bus.sent_total}, 3);
`else
        chk("t4_sent_total", {16'd0, bus.sent_total}, 0);
`endif

        // back-to-back with req_valid held
        obs_clear();
        n = cur;
        bus.req_valid = 1'b1;
        bus.req_count = 8'd1;
        bus.req_gap   = 4'd1;
        tick(4);
        bus.req_valid = 1'b0;
        tick(6);
        q = {n + 1, n + 4};
        chk_list("t5_pulses", obs_pulse, q);
        q = {n + 3, n + 6};
        chk_list("t5_done", obs_done, q);

        // reset mid-GAP
        obs_clear();
        request(4, 5);
        tick(2);
        do_reset();
        obs_clear();
        tick(15);
        q = {};
        chk_list("t6_pulses", obs_pulse, q);
        chk_list("t6_done", obs_done, q);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            bus.req_valid = ($urandom % 4) == 0;
            bus.req_count = (($urandom % 10) < 7) ? 8'($urandom % 5) : 8'($urandom % 24);
            bus.req_gap   = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 3);
            bus.abort     = ($urandom % 40) == 0;
            if (($urandom % 1000) == 0) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
            tick(1);
        end
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        tick(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
